mem_req_port: RTL and testbench
===============================

MEM_REQ_PORT -- requirements
Module: mem_req_port

Interface
REQ-001 SHALL have parameter CL_SIZE, default 128, cache line width in bits.
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum outstanding memory requests.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: cache request handshake.
REQ-006 SHALL have ports req_addr in 32, req_data in CL_SIZE, req_op in 3, req_is_instr in 1, req_is_flush in 1, req_src in 2, req_dest in 2.
REQ-007 SHALL have data-queue outputs addr_out_mem_data_q (32), data_out_mem_data_q (CL_SIZE), operation_out_mem_data_q (3), is_flush_out_mem_data_q (1), alloc_out_mem_data_q (1), src_out_mem_data_q (2), dest_out_mem_data_q (2), and input full_in_mem_data_q (1).
REQ-008 SHALL have instr-queue outputs addr/operation/is_flush/alloc/src/dest_out_mem_instr_q (32/3/1/1/2/2, no data), and input full_in_mem_instr_q (1).
REQ-009 SHALL have response inputs addr_in_resp (32), data_in_resp (CL_SIZE), operation_in_resp (3), is_flush_in_resp (1), alloc_in_resp (1), src_in_resp (2), dest_in_resp (2), and output full_out_resp (1).
REQ-010 SHALL have cache response outputs resp_valid (1), resp_addr (32), resp_data (CL_SIZE), resp_op (3), resp_src (2), resp_dest (2), input resp_ready (1), and output err_unexpected_resp (1).

Function
REQ-011 Issue FSM SHALL have states IDLE and SEND.
REQ-012 req_ready SHALL be 1 only in IDLE with outstanding count < MAX_OUT.
REQ-013 On req_valid & req_ready: request fields SHALL be registered; FSM -> SEND next cycle.
REQ-014 Target queue SHALL be instr queue iff req_is_instr=1 and req_op is not OP_WRITE; otherwise data queue.
REQ-015 In SEND: if target full_in_* = 0, alloc_out of target SHALL pulse high exactly one cycle with registered fields; FSM -> IDLE; outstanding +1.
REQ-016 In SEND with target full_in_* = 1: SHALL hold SEND, alloc low, fields stable, until full deasserts.
REQ-017 At most one of the two alloc outputs SHALL be high in any cycle; non-target queue outputs SHALL hold last values with alloc low.
REQ-018 Every issued request (read, write, flush) SHALL produce exactly one response; no other ordering assumption.
REQ-019 Responses SHALL be captured into a 2-entry FIFO when alloc_in_resp=1 and full_out_resp=0; full_out_resp = (FIFO count == 2), registered.
REQ-020 Each captured response SHALL decrement outstanding; capture and issue in the same cycle SHALL leave count unchanged.
REQ-021 alloc_in_resp while outstanding==0 SHALL be dropped (not enqueued) and set err_unexpected_resp sticky until reset.
REQ-022 alloc_in_resp while full_out_resp=1 SHALL be ignored (sender protocol violation, no state change).
REQ-023 resp_valid SHALL equal FIFO non-empty; head pops on resp_valid & resp_ready; push and pop in one cycle on a 1-entry FIFO SHALL keep count 1.
REQ-024 Outstanding counter width SHALL be clog2(MAX_OUT+1); it SHALL never wrap.

Reset
REQ-025 On rst: FSM=IDLE, outstanding=0, FIFO empty, all alloc outputs 0, resp_valid 0, full_out_resp 0, err_unexpected_resp 0, all address/data/field outputs 0.
REQ-026 Reset mid-SEND SHALL abandon the request; no alloc pulse after rst deasserts until a new handshake.

Structure
REQ-027 Operation encodings (OP_READ=0, OP_WRITE=1, OP_FLUSH=2, OP_RFO=3) and queue-select constants SHALL live in shared package mem_pkg.
REQ-028 The response FIFO SHALL be a sub-module resp_fifo (depth 2, CL_SIZE+41 bits); FSM and counter inline.

Verification
REQ-029 Read addr 0x0000_0040, is_instr=1, queues not full -> alloc_out_mem_instr_q high exactly one cycle, 2 cycles after handshake, addr 0x40, op 0.
REQ-030 Write addr 0x80, data 0xDEAD..BEEF, is_instr=1 -> routed to data queue; data_out matches; instr alloc stays 0.
REQ-031 full_in_mem_data_q held 1 for 5 cycles during SEND -> no alloc, fields stable; alloc pulses cycle after full drops.
REQ-032 Issue 4 reads without responses -> req_ready 0 after 4th; one response -> req_ready 1 next cycle.
REQ-033 Three back-to-back responses with resp_ready=0 -> full_out_resp 1 after two; third ignored; pops drain two in order.
REQ-034 Response with outstanding=0 -> resp_valid stays 0, err_unexpected_resp 1 until rst.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-request encodings: operation codes, queue select and response metadata layout.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_FLUSH = 3'd2,
    OP_RFO   = 3'd3
  } op_e;

  typedef enum logic {
    Q_DATA  = 1'b0,
    Q_INSTR = 1'b1
  } qsel_e;

  // Everything a response carries except the cache line itself.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  op;
    logic        is_flush;
    logic        alloc;
    logic [1:0]  src;
    logic [1:0]  dest;
  } meta_t;

  localparam int META_W = $bits(meta_t);

  // Instruction fetches go to the instr queue; writes always need the data path.
  function automatic qsel_e select_queue(input logic is_instr, input logic [2:0] op);
    return (is_instr && (op != OP_WRITE)) ? Q_INSTR : Q_DATA;
  endfunction

endpackage

// File: rtl/mem_req_port_if.sv
// Bundle of cache-side handshakes, memory queue ports and response ports of mem_req_port.
interface mem_req_port_if #(
  parameter int CL_SIZE = 128
);
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic [CL_SIZE-1:0] req_data;
  logic [2:0]         req_op;
  logic               req_is_instr;
  logic               req_is_flush;
  logic [1:0]         req_src;
  logic [1:0]         req_dest;

  logic [31:0]        addr_out_mem_data_q;
  logic [CL_SIZE-1:0] data_out_mem_data_q;
  logic [2:0]         operation_out_mem_data_q;
  logic               is_flush_out_mem_data_q;
  logic               alloc_out_mem_data_q;
  logic [1:0]         src_out_mem_data_q;
  logic [1:0]         dest_out_mem_data_q;
  logic               full_in_mem_data_q;

  logic [31:0]        addr_out_mem_instr_q;
  logic [2:0]         operation_out_mem_instr_q;
  logic               is_flush_out_mem_instr_q;
  logic               alloc_out_mem_instr_q;
  logic [1:0]         src_out_mem_instr_q;
  logic [1:0]         dest_out_mem_instr_q;
  logic               full_in_mem_instr_q;

  logic [31:0]        addr_in_resp;
  logic [CL_SIZE-1:0] data_in_resp;
  logic [2:0]         operation_in_resp;
  logic               is_flush_in_resp;
  logic               alloc_in_resp;
  logic [1:0]         src_in_resp;
  logic [1:0]         dest_in_resp;
  logic               full_out_resp;

  logic               resp_valid;
  logic [31:0]        resp_addr;
  logic [CL_SIZE-1:0] resp_data;
  logic [2:0]         resp_op;
  logic [1:0]         resp_src;
  logic [1:0]         resp_dest;
  logic               resp_ready;
  logic               err_unexpected_resp;

  modport slave (
    input  req_valid, req_addr, req_data, req_op, req_is_instr, req_is_flush, req_src, req_dest,
    output req_ready,
    output addr_out_mem_data_q, data_out_mem_data_q, operation_out_mem_data_q,
           is_flush_out_mem_data_q, alloc_out_mem_data_q, src_out_mem_data_q, dest_out_mem_data_q,
    input  full_in_mem_data_q,
    output addr_out_mem_instr_q, operation_out_mem_instr_q, is_flush_out_mem_instr_q,
           alloc_out_mem_instr_q, src_out_mem_instr_q, dest_out_mem_instr_q,
    input  full_in_mem_instr_q,
    input  addr_in_resp, data_in_resp, operation_in_resp, is_flush_in_resp, alloc_in_resp,
           src_in_resp, dest_in_resp,
    output full_out_resp,
    output resp_valid, resp_addr, resp_data, resp_op, resp_src, resp_dest, err_unexpected_resp,
    input  resp_ready
  );

  modport master (
    output req_valid, req_addr, req_data, req_op, req_is_instr, req_is_flush, req_src, req_dest,
    input  req_ready,
    input  addr_out_mem_data_q, data_out_mem_data_q, operation_out_mem_data_q,
           is_flush_out_mem_data_q, alloc_out_mem_data_q, src_out_mem_data_q, dest_out_mem_data_q,
    output full_in_mem_data_q,
    input  addr_out_mem_instr_q, operation_out_mem_instr_q, is_flush_out_mem_instr_q,
           alloc_out_mem_instr_q, src_out_mem_instr_q, dest_out_mem_instr_q,
    output full_in_mem_instr_q,
    output addr_in_resp, data_in_resp, operation_in_resp, is_flush_in_resp, alloc_in_resp,
           src_in_resp, dest_in_resp,
    input  full_out_resp,
    input  resp_valid, resp_addr, resp_data, resp_op, resp_src, resp_dest, err_unexpected_resp,
    output resp_ready
  );
endinterface

// File: rtl/mem_req_port_resp_fifo.sv
// Two-entry response FIFO.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full is registered; pushes while full are ignored, head holds until out_rdy.
module resp_fifo #(
  parameter int W = 169
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         full,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic [1:0]   cnt_n;
  logic         push;
  logic         pop;

  assign push    = in_vld && !full;
  assign out_vld = (cnt != 2'd0);
  assign pop     = out_rdy && out_vld;
  assign out_dat = mem[rd_ptr];

  always_comb begin
    cnt_n = cnt;
    if (push && !pop)
      cnt_n = cnt + 2'd1;
    else if (pop && !push)
      cnt_n = cnt - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      full   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      cnt  <= cnt_n;
      full <= (cnt_n == 2'd2);
    end
  end
endmodule

// File: rtl/mem_req_port.sv
// Cache-to-memory request port: routes requests to instr/data queues, tracks outstanding, buffers responses.
// Latency: queue alloc pulses 2 cycles after the request handshake; responses appear 1 cycle after capture.
// Backpressure: holds in SEND while the target queue is full; req_ready drops at MAX_OUT outstanding.
module mem_req_port
  import mem_pkg::*;
#(
  parameter int CL_SIZE = 128,
  parameter int MAX_OUT = 4
) (
  input logic           clk,
  input logic           rst,
  mem_req_port_if.slave bus
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int RW = CL_SIZE + META_W;

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state;
  logic [CW-1:0]      outstanding;
  logic [31:0]        cur_addr;
  logic [CL_SIZE-1:0] cur_data;
  logic [2:0]         cur_op;
  logic               cur_is_flush;
  logic [1:0]         cur_src;
  logic [1:0]         cur_dest;
  qsel_e              cur_q;

  logic               target_full;
  logic               issue;
  logic               capture;
  logic               resp_full;
  meta_t              in_meta;
  logic [RW-1:0]      head;
  meta_t              head_meta;
  logic               unused_resp_bits;

  assign bus.req_ready = (state == IDLE) && (outstanding < CW'(MAX_OUT));
  assign target_full   = (cur_q == Q_INSTR) ? bus.full_in_mem_instr_q : bus.full_in_mem_data_q;
  assign issue         = (state == SEND) && !target_full;
  // A response with nothing outstanding is never enqueued, so the counter cannot underflow.
  assign capture       = bus.alloc_in_resp && !resp_full && (outstanding != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                         <= IDLE;
      outstanding                   <= '0;
      cur_addr                      <= '0;
      cur_data                      <= '0;
      cur_op                        <= '0;
      cur_is_flush                  <= 1'b0;
      cur_src                       <= '0;
      cur_dest                      <= '0;
      cur_q                         <= Q_DATA;
      bus.addr_out_mem_data_q       <= '0;
      bus.data_out_mem_data_q       <= '0;
      bus.operation_out_mem_data_q  <= '0;
      bus.is_flush_out_mem_data_q   <= 1'b0;
      bus.alloc_out_mem_data_q      <= 1'b0;
      bus.src_out_mem_data_q        <= '0;
      bus.dest_out_mem_data_q       <= '0;
      bus.addr_out_mem_instr_q      <= '0;
      bus.operation_out_mem_instr_q <= '0;
      bus.is_flush_out_mem_instr_q  <= 1'b0;
      bus.alloc_out_mem_instr_q     <= 1'b0;
      bus.src_out_mem_instr_q       <= '0;
      bus.dest_out_mem_instr_q      <= '0;
      bus.err_unexpected_resp       <= 1'b0;
    end else begin
      bus.alloc_out_mem_data_q  <= 1'b0;
      bus.alloc_out_mem_instr_q <= 1'b0;

      if (issue && !capture)
        outstanding <= outstanding + CW'(1);
      else if (capture && !issue)
        outstanding <= outstanding - CW'(1);

      if (bus.alloc_in_resp && !resp_full && (outstanding == '0))
        bus.err_unexpected_resp <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            cur_addr     <= bus.req_addr;
            cur_data     <= bus.req_data;
            cur_op       <= bus.req_op;
            cur_is_flush <= bus.req_is_flush;
            cur_src      <= bus.req_src;
            cur_dest     <= bus.req_dest;
            cur_q        <= select_queue(bus.req_is_instr, bus.req_op);
            state        <= SEND;
          end
        end
        SEND: begin
          if (!target_full) begin
            if (cur_q == Q_INSTR) begin
              bus.addr_out_mem_instr_q      <= cur_addr;
              bus.operation_out_mem_instr_q <= cur_op;
              bus.is_flush_out_mem_instr_q  <= cur_is_flush;
              bus.src_out_mem_instr_q       <= cur_src;
              bus.dest_out_mem_instr_q      <= cur_dest;
              bus.alloc_out_mem_instr_q     <= 1'b1;
            end else begin
              bus.addr_out_mem_data_q       <= cur_addr;
              bus.data_out_mem_data_q       <= cur_data;
              bus.operation_out_mem_data_q  <= cur_op;
              bus.is_flush_out_mem_data_q   <= cur_is_flush;
              bus.src_out_mem_data_q        <= cur_src;
              bus.dest_out_mem_data_q       <= cur_dest;
              bus.alloc_out_mem_data_q      <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_meta = {bus.addr_in_resp, bus.operation_in_resp, bus.is_flush_in_resp,
                    bus.alloc_in_resp, bus.src_in_resp, bus.dest_in_resp};

  resp_fifo #(.W(RW)) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (capture),
    .in_dat  ({in_meta, bus.data_in_resp}),
    .full    (resp_full),
    .out_vld (bus.resp_valid),
    .out_rdy (bus.resp_ready),
    .out_dat (head)
  );

  assign head_meta         = head[RW-1:CL_SIZE];
  assign bus.full_out_resp = resp_full;
  assign bus.resp_addr     = head_meta.addr;
  assign bus.resp_op       = head_meta.op;
  assign bus.resp_src      = head_meta.src;
  assign bus.resp_dest     = head_meta.dest;
  assign bus.resp_data     = head[CL_SIZE-1:0];
  assign unused_resp_bits  = head_meta.is_flush ^ head_meta.alloc;
endmodule

// File: tb/tb_mem_req_port.sv
// Self-checking bench for mem_req_port: vector table for routing, scoreboards for issue and response paths.
module tb_mem_req_port;
  import mem_pkg::*;

  localparam int CL = 128;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_req_port_if #(.CL_SIZE(CL)) bus ();
  mem_req_port #(.CL_SIZE(CL), .MAX_OUT(MO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          instr;
    logic [31:0]   addr;
    logic [CL-1:0] data;
    logic [2:0]    op;
    logic          fl;
    logic [1:0]    src;
    logic [1:0]    dest;
  } iss_t;

  typedef struct {
    logic [31:0]   addr;
    logic [CL-1:0] data;
    logic [2:0]    op;
    logic [1:0]    src;
    logic [1:0]    dest;
  } rsp_t;

  typedef struct {
    logic [31:0]   addr;
    logic [CL-1:0] data;
    logic [2:0]    op;
    logic          is_instr;
    logic          fl;
    logic [1:0]    src;
    logic [1:0]    dest;
    logic          exp_instr;
  } vec_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] last_data_addr = '0;

  task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  task automatic send_req(input vec_t v);
    iss_t e;
    int   n = 0;
    bus.req_addr     = v.addr;
    bus.req_data     = v.data;
    bus.req_op       = v.op;
    bus.req_is_instr = v.is_instr;
    bus.req_is_flush = v.fl;
    bus.req_src      = v.src;
    bus.req_dest     = v.dest;
    bus.req_valid    = 1'b1;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", bus.req_ready, 1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    e.instr = v.exp_instr;
    e.addr  = v.addr;
    e.data  = v.data;
    e.op    = v.op;
    e.fl    = v.fl;
    e.src   = v.src;
    e.dest  = v.dest;
    iss_q.push_back(e);
    if (!v.exp_instr) last_data_addr = v.addr;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send_resp(input rsp_t r, input bit cap);
    bus.addr_in_resp      = r.addr;
    bus.data_in_resp      = r.data;
    bus.operation_in_resp = r.op;
    bus.is_flush_in_resp  = 1'b0;
    bus.src_in_resp       = r.src;
    bus.dest_in_resp      = r.dest;
    bus.alloc_in_resp     = 1'b1;
    if (cap) rsp_q.push_back(r);
    @(posedge clk); #1;
    bus.alloc_in_resp = 1'b0;
  endtask

  // Scoreboard side: compare every alloc pulse and every popped response.
  always @(negedge clk) begin : mon
    iss_t e;
    rsp_t r;
    if (!rst) begin
      if (bus.alloc_out_mem_instr_q || bus.alloc_out_mem_data_q) begin
        check("alloc_onehot", bus.alloc_out_mem_instr_q & bus.alloc_out_mem_data_q, 0);
        if (iss_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL alloc_spurious: instr=%0b data=%0b, required no alloc",
                   bus.alloc_out_mem_instr_q, bus.alloc_out_mem_data_q);
        end else begin
          e = iss_q.pop_front();
          check("alloc_queue", bus.alloc_out_mem_instr_q, e.instr);
          if (e.instr) begin
            check("iq_addr", bus.addr_out_mem_instr_q, e.addr);
            check("iq_op", bus.operation_out_mem_instr_q, e.op);
            check("iq_flush", bus.is_flush_out_mem_instr_q, e.fl);
            check("iq_src", bus.src_out_mem_instr_q, e.src);
            check("iq_dest", bus.dest_out_mem_instr_q, e.dest);
          end else begin
            check("dq_addr", bus.addr_out_mem_data_q, e.addr);
            check("dq_data", bus.data_out_mem_data_q, e.data);
            check("dq_op", bus.operation_out_mem_data_q, e.op);
            check("dq_flush", bus.is_flush_out_mem_data_q, e.fl);
            check("dq_src", bus.src_out_mem_data_q, e.src);
            check("dq_dest", bus.dest_out_mem_data_q, e.dest);
          end
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (rsp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp_spurious: resp_addr=%0h, required no response", bus.resp_addr);
        end else begin
          r = rsp_q.pop_front();
          check("resp_addr", bus.resp_addr, r.addr);
          check("resp_data", bus.resp_data, r.data);
          check("resp_op", bus.resp_op, r.op);
          check("resp_src", bus.resp_src, r.src);
          check("resp_dest", bus.resp_dest, r.dest);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[6];
    vec_t        v;
    rsp_t        r;
    logic [31:0] prev;

    tbl[0] = '{32'h0000_0080, 128'hDEAD_C0DE_0123_4567_89AB_CDEF_5555_BEEF, OP_WRITE, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0};
    tbl[1] = '{32'h0000_0100, 128'h1111_2222_3333_4444_5555_6666_7777_8888, OP_READ,  1'b0, 1'b0, 2'd2, 2'd3, 1'b0};
    tbl[2] = '{32'h0000_01C0, 128'h0,                                      OP_FLUSH, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1};
    tbl[3] = '{32'h0000_0240, 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A, OP_RFO,   1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
    tbl[4] = '{32'hFFFF_FFC0, 128'h0,                                      OP_READ,  1'b1, 1'b0, 2'd2, 2'd1, 1'b1};
    tbl[5] = '{32'h0000_0300, 128'h0,                                      OP_RFO,   1'b1, 1'b0, 2'd1, 2'd1, 1'b1};

    rst                     = 1'b1;
    bus.req_valid           = 1'b0;
    bus.req_addr            = '0;
    bus.req_data            = '0;
    bus.req_op              = '0;
    bus.req_is_instr        = 1'b0;
    bus.req_is_flush        = 1'b0;
    bus.req_src             = '0;
    bus.req_dest            = '0;
    bus.full_in_mem_data_q  = 1'b0;
    bus.full_in_mem_instr_q = 1'b0;
    bus.addr_in_resp        = '0;
    bus.data_in_resp        = '0;
    bus.operation_in_resp   = '0;
    bus.is_flush_in_resp    = 1'b0;
    bus.alloc_in_resp       = 1'b0;
    bus.src_in_resp         = '0;
    bus.dest_in_resp        = '0;
    bus.resp_ready          = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_alloc_instr", bus.alloc_out_mem_instr_q, 0);
    check("rst_alloc_data", bus.alloc_out_mem_data_q, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_full_out", bus.full_out_resp, 0);
    check("rst_err", bus.err_unexpected_resp, 0);
    check("rst_dq_addr", bus.addr_out_mem_data_q, 0);
    check("rst_iq_addr", bus.addr_out_mem_instr_q, 0);
    check("rst_dq_data", bus.data_out_mem_data_q, 0);
    check("rst_resp_addr", bus.resp_addr, 0);
    check("rst_req_ready", bus.req_ready, 1);

    // Instruction read: alloc exactly one cycle, two cycles after the handshake.
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    v = '{32'h0000_0040, 128'h0, OP_READ, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};
    send_req(v);
    @(negedge clk); check("lat_cycle1", bus.alloc_out_mem_instr_q, 0);
    @(negedge clk); check("lat_cycle2", bus.alloc_out_mem_instr_q, 1);
    @(negedge clk); check("lat_cycle3", bus.alloc_out_mem_instr_q, 0);
    r = '{32'h0000_0040, 128'h40, OP_READ, 2'd0, 2'd0};
    send_resp(r, 1'b1);
    repeat (3) @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send_req(tbl[i]);
      repeat (3) @(posedge clk); #1;
      r = '{tbl[i].addr, ~tbl[i].data, tbl[i].op, tbl[i].dest, tbl[i].src};
      send_resp(r, 1'b1);
      repeat (2) @(posedge clk); #1;
    end

    // Data queue full for 5 cycles while in SEND.
    prev = last_data_addr;
    bus.full_in_mem_data_q = 1'b1;
    v = '{32'h0000_0500, 128'h5555_0000_1234_5678_0000_0000_9ABC_DEF0, OP_WRITE, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0};
    send_req(v);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("full_hold_alloc", bus.alloc_out_mem_data_q, 0);
      check("full_hold_addr", bus.addr_out_mem_data_q, prev);
    end
    @(posedge clk); #1;
    bus.full_in_mem_data_q = 1'b0;
    @(negedge clk); check("full_drop_same", bus.alloc_out_mem_data_q, 0);
    @(negedge clk); check("full_drop_next", bus.alloc_out_mem_data_q, 1);
    r = '{32'h0000_0500, 128'h0, OP_WRITE, 2'd3, 2'd1};
    send_resp(r, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Fill the outstanding limit.
    for (int i = 0; i < 4; i++) begin
      v = '{32'h0000_1000 + 32'(i * 64), 128'h0, OP_READ, 1'b0, 1'b0, 2'(i), 2'd0, 1'b0};
      send_req(v);
    end
    repeat (3) @(posedge clk); #1;
    check("ready_at_max", bus.req_ready, 0);
    r = '{32'h0000_1000, 128'hF00D, OP_READ, 2'd0, 2'd0};
    send_resp(r, 1'b1);
    check("ready_after_resp", bus.req_ready, 1);
    repeat (2) @(posedge clk); #1;

    // Three back-to-back responses against a stalled consumer.
    bus.resp_ready = 1'b0;
    r = '{32'h0000_1040, 128'h1, OP_READ, 2'd1, 2'd0};
    send_resp(r, 1'b1);
    check("fifo_one_full", bus.full_out_resp, 0);
    r = '{32'h0000_1080, 128'h2, OP_READ, 2'd2, 2'd0};
    send_resp(r, 1'b1);
    check("fifo_two_full", bus.full_out_resp, 1);
    r = '{32'h0000_10C0, 128'h3, OP_READ, 2'd3, 2'd0};
    send_resp(r, 1'b0);
    check("fifo_third_full", bus.full_out_resp, 1);
    check("fifo_third_valid", bus.resp_valid, 1);
    check("fifo_third_err", bus.err_unexpected_resp, 0);
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("drain_full", bus.full_out_resp, 0);
    check("drain_valid", bus.resp_valid, 0);
    r = '{32'h0000_10C0, 128'h3, OP_READ, 2'd3, 2'd0};
    send_resp(r, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("last_resp_err", bus.err_unexpected_resp, 0);

    // Response with nothing outstanding.
    r = '{32'h0000_DEAD, 128'hBAD, OP_READ, 2'd0, 2'd0};
    send_resp(r, 1'b0);
    @(negedge clk);
    check("unexp_valid", bus.resp_valid, 0);
    check("unexp_err", bus.err_unexpected_resp, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("unexp_err_sticky", bus.err_unexpected_resp, 1);

    // Reset while stuck in SEND abandons the request.
    @(posedge clk); #1;
    bus.full_in_mem_data_q = 1'b1;
    v = '{32'h0000_0600, 128'h6, OP_WRITE, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    send_req(v);
    repeat (2) @(posedge clk); #1;
    iss_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_err", bus.err_unexpected_resp, 0);
    check("rst_mid_dq_addr", bus.addr_out_mem_data_q, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.full_in_mem_data_q = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_mid_no_alloc", bus.alloc_out_mem_data_q | bus.alloc_out_mem_instr_q, 0);
    end
    check("rst_mid_ready", bus.req_ready, 1);

    check("iss_q_drained", iss_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
